// File: rtl/baud_rate_gen_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//   Shared constants for the UART baud-rate generator: register addresses
//   for the two divisor bytes, default geometry, and ready-made divisors for
//   a 50 MHz clock with 16x oversampling (DB = f_clk / (16 * baud) - 1).
// ---------------------------------------------------------------------------
package baud_pkg;

  // Byte-wide divisor register map.
  localparam logic ADDR_DB_LO = 1'b0;
  localparam logic ADDR_DB_HI = 1'b1;

  // Default geometry.
  localparam int DEFAULT_DIV_W      = 16;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Divisors for 50 MHz at 16x oversampling.
  localparam int DIV_4800  = 650;
  localparam int DIV_9600  = 325;
  localparam int DIV_19200 = 162;
  localparam int DIV_38400 = 80;

endpackage : baud_pkg

// File: rtl/baud_rate_gen_if.sv
// ---------------------------------------------------------------------------
// baud_rate_gen_if
//   Register-write and tick bundle between the bus/register decode, the
//   baud-rate generator and the UART engines.
//   master : drives enable / wr_en / wr_addr / wr_data, observes ticks, div_q
//   slave  : the generator itself
// ---------------------------------------------------------------------------
interface baud_rate_gen_if
  import baud_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
);

  logic             enable;   // tick generation enable
  logic             wr_en;    // one-cycle divisor write strobe
  logic             wr_addr;  // ADDR_DB_LO / ADDR_DB_HI
  logic [7:0]       wr_data;  // write data
  logic             rx_tick;  // oversample pulse, every DB+1 enabled cycles
  logic             tx_tick;  // bit pulse, every OVERSAMPLE rx_ticks
  logic [DIV_W-1:0] div_q;    // active divisor readback

  modport master (
    output enable, wr_en, wr_addr, wr_data,
    input  rx_tick, tx_tick, div_q
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data,
    output rx_tick, tx_tick, div_q
  );

endinterface : baud_rate_gen_if

// File: rtl/baud_rate_gen_tick_div.sv
// ---------------------------------------------------------------------------
// baud_tick_div
//   Generic mod-N event counter. Every cycle with advance=1 moves the count
//   on by one; the advance that wraps N-1 -> 0 produces a registered one-cycle
//   tick, aligned with any other output registered from the same advance.
//   clear has priority and returns the count to 0 with no tick.
//   Ports: clk, rst_n (async, active-low), clear, advance, tick.
// ---------------------------------------------------------------------------
module baud_tick_div #(
  parameter  int N     = 16,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (advance) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule : baud_tick_div

// File: rtl/baud_rate_gen.sv
// ---------------------------------------------------------------------------
// baud_rate_gen
//   Programmable baud-rate generator. A divisor DB, loaded a byte at a time
//   (low byte staged, high byte commits atomically), sets the rx oversample
//   tick period to DB+1 enabled cycles; tx_tick fires on every OVERSAMPLE-th
//   rx_tick, in the same cycle. All outputs are registered.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    baud_rate_gen_if.slave (enable, divisor writes, ticks, div_q)
// ---------------------------------------------------------------------------
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int DIV_W      = DEFAULT_DIV_W,       // 9..16
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,  // >= 2
  parameter int RESET_DIV  = DIV_9600
) (
  input  logic            clk,
  input  logic            rst_n,
  baud_rate_gen_if.slave  bus
);

  localparam logic [DIV_W-1:0] RESET_DB = DIV_W'(RESET_DIV);

  logic [DIV_W-1:0] db;        // active divisor
  logic [7:0]       lo_stage;  // staged low byte, applied by the next high write
  logic [DIV_W-1:0] down_cnt;
  logic [DIV_W-1:0] new_db;
  logic             lo_wr;
  logic             commit;
  logic             rx_event;  // this edge issues an rx_tick
  logic             rx_tick_q;
  logic             tx_tick_q;

  assign lo_wr  = bus.wr_en && (bus.wr_addr == ADDR_DB_LO);
  assign commit = bus.wr_en && (bus.wr_addr == ADDR_DB_HI);
  // wr_data bits above the divisor width are dropped.
  assign new_db = {bus.wr_data[DIV_W-9:0], lo_stage};

  // A commit or a disabled cycle suppresses the terminal-count tick.
  assign rx_event = bus.enable && !commit && (down_cnt == '0);

  // Divisor register and low-byte staging. Writes are accepted regardless
  // of enable.
  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low reset so every flop samples pre-edge values consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db       <= RESET_DB;
      lo_stage <= RESET_DB[7:0];
    end else begin
      if (lo_wr)  lo_stage <= bus.wr_data;
      if (commit) db       <= new_db;
    end
  end

  // Main down-counter. Idles at DB while disabled, so that a re-enable (or a
  // commit) starts a full DB+1 period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_cnt  <= RESET_DB;
      rx_tick_q <= 1'b0;
    end else if (commit) begin
      down_cnt  <= new_db;
      rx_tick_q <= 1'b0;
    end else if (!bus.enable) begin
      down_cnt  <= db;
      rx_tick_q <= 1'b0;
    end else if (down_cnt == '0) begin
      down_cnt  <= db;
      rx_tick_q <= 1'b1;
    end else begin
      down_cnt  <= down_cnt - 1'b1;
      rx_tick_q <= 1'b0;
    end
  end

  // Oversample stage: advanced by the same event that raises rx_tick, so
  // the wrapping rx_tick and tx_tick land in the same cycle.
  baud_tick_div #(
    .N (OVERSAMPLE)
  ) u_tx_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (commit || !bus.enable),
    .advance (rx_event),
    .tick    (tx_tick_q)
  );

  assign bus.rx_tick = rx_tick_q;
  assign bus.tx_tick = tx_tick_q;
  assign bus.div_q   = db;

endmodule : baud_rate_gen
